// File: rtl/gf2m_mul_arbiter.sv
// gf2m_mul_arbiter: round-robin sharing of one digit-serial GF(2^m) multiplier among NREQ requesters
module gf2m_mul_arbiter #(
    parameter int WIDTH   = 107,
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*WIDTH-1:0] req_op_a,
    input  logic [NREQ*WIDTH-1:0] req_op_b,
    output logic [NREQ-1:0]       resp_valid,
    input  logic [NREQ-1:0]       resp_ready,
    output logic [WIDTH-1:0]      resp_data,
    output logic                  resp_err,
    output logic                  mul_start,
    output logic [WIDTH-1:0]      mul_op_a,
    output logic [WIDTH-1:0]      mul_op_b,
    input  logic                  mul_done,
    input  logic [WIDTH-1:0]      mul_op_c,
    output logic                  err_sticky
);
    localparam int PW = $clog2(NREQ);
    localparam int CW = $clog2(TIMEOUT + 1);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
    state_t        state;
    logic [PW-1:0] ptr, id, grant;
    logic [CW-1:0] cnt;
    logic          found;
    always_comb begin
        grant = ptr;
        found = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            if (!found && req_valid[(int'(ptr) + k) % NREQ]) begin
                grant = PW'((int'(ptr) + k) % NREQ);
                found = 1'b1;
            end
        end
    end
    assign req_ready = (state == IDLE && found) ? NREQ'(1) << grant : '0;
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            ptr        <= '0;
            id         <= '0;
            cnt        <= '0;
            resp_valid <= '0;
            resp_data  <= '0;
            resp_err   <= 1'b0;
            mul_start  <= 1'b0;
            mul_op_a   <= '0;
            mul_op_b   <= '0;
            err_sticky <= 1'b0;
        end else begin
            mul_start <= 1'b0;
            // a done pulse with no operation waiting on it is a protocol error
            if (mul_done && state != WAIT) err_sticky <= 1'b1;
            case (state)
                IDLE: if (found) begin
                    mul_op_a  <= req_op_a[int'(grant) * WIDTH +: WIDTH];
                    mul_op_b  <= req_op_b[int'(grant) * WIDTH +: WIDTH];
                    id        <= grant;
                    ptr       <= PW'((int'(grant) + 1) % NREQ);
                    mul_start <= 1'b1;
                    state     <= ISSUE;
                end
                ISSUE: begin
                    cnt   <= '0;
                    state <= WAIT;
                end
                WAIT: if (mul_done) begin
                    resp_data  <= mul_op_c;
                    resp_err   <= 1'b0;
                    resp_valid <= NREQ'(1) << id;
                    state      <= RESP;
                end else if (cnt == CW'(TIMEOUT - 1)) begin
                    resp_data  <= '0;
                    resp_err   <= 1'b1;
                    err_sticky <= 1'b1;
                    resp_valid <= NREQ'(1) << id;
                    state      <= RESP;
                end else begin
                    cnt <= cnt + 1'b1;
                end
                RESP: if (resp_ready[id]) begin
                    resp_valid <= '0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_gf2m_mul_arbiter.sv
// tb_gf2m_mul_arbiter: scoreboard bench with a behavioural fixed-latency multiplier model
module tb_gf2m_mul_arbiter;
    localparam int W   = 107;
    localparam int N   = 4;
    localparam int TO  = 16;
    localparam int LAT = W / 16 + 2;
    typedef struct { int id; logic [W-1:0] d; logic e; } exp_t;
    typedef struct { int id; logic [W-1:0] a; logic [W-1:0] b; logic [W-1:0] d; } vec_t;

    logic clk = 1'b0, rst = 1'b1;
    logic [N-1:0] req_valid = '0, resp_ready = '1;
    logic [N-1:0] req_ready, resp_valid;
    logic [N*W-1:0] req_op_a = '0, req_op_b = '0;
    logic [W-1:0] resp_data, mul_op_a, mul_op_b;
    logic [W-1:0] mul_op_c = '0;
    logic resp_err, mul_start, err_sticky;
    logic mul_done = 1'b0;
    int errors = 0, checks = 0, nstart = 0, mdl_cnt = 0;
    logic prev_start = 1'b0, mdl_hang = 1'b0;
    logic [W-1:0] mdl_a, mdl_b;
    exp_t sb[$];
    exp_t mon_e;
    int glog[$];

    gf2m_mul_arbiter #(.WIDTH(W), .NREQ(N), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_op_a(req_op_a), .req_op_b(req_op_b),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_data(resp_data), .resp_err(resp_err),
        .mul_start(mul_start), .mul_op_a(mul_op_a), .mul_op_b(mul_op_b),
        .mul_done(mul_done), .mul_op_c(mul_op_c), .err_sticky(err_sticky)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] gf_mul(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] r = '0;
        for (int i = W - 1; i >= 0; i--) begin
            r = {r[W-2:0], 1'b0} ^ (r[W-1] ? W'('h291) : '0);
            if (b[i]) r ^= a;
        end
        return r;
    endfunction

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, want);
        end
    endtask

    // multiplier: fixed latency after start, drives junk on the result bus when not done
    always @(negedge clk) begin
        mul_done = 1'b0;
        mul_op_c = '1;
        if (mul_start && !mdl_hang) begin
            mdl_cnt = LAT;
            mdl_a = mul_op_a;
            mdl_b = mul_op_b;
        end else if (mdl_cnt > 0) begin
            mdl_cnt--;
            if (mdl_cnt == 0) begin
                mul_done = 1'b1;
                mul_op_c = gf_mul(mdl_a, mdl_b);
            end
        end
    end

    always @(negedge clk) begin
        #1;
        if (mul_start) begin
            nstart++;
            chk("start_one_cycle", W'(prev_start), '0);
        end
        prev_start = mul_start;
        if (|(resp_valid & resp_ready)) begin
            if (sb.size() == 0) chk("resp_unexpected", W'(resp_valid), '0);
            else begin
                mon_e = sb.pop_front();
                chk("resp_onehot", W'(resp_valid), W'(1) << mon_e.id);
                chk("resp_data", resp_data, mon_e.d);
                chk("resp_err", W'(resp_err), W'(mon_e.e));
            end
        end
    end

    // caller must be at a falling edge; returns at the falling edge after the handshake
    task automatic serve(input int id, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] d, input logic e, input bit track);
        bit hs = 1'b0;
        int n = 0;
        exp_t x;
        req_op_a[id*W +: W] = a;
        req_op_b[id*W +: W] = b;
        req_valid[id] = 1'b1;
        while (!hs && n < 200) begin
            #1;
            hs = req_ready[id];
            if (!hs) begin
                @(negedge clk);
                n++;
            end
        end
        if (!hs) begin
            checks++;
            errors++;
            $display("FAIL grant_timeout: requester %0d never granted", id);
        end else begin
            glog.push_back(id);
            if (track) begin
                x.id = id;
                x.d = d;
                x.e = e;
                sb.push_back(x);
            end
        end
        @(negedge clk);
        req_valid[id] = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            chk("drain_timeout", W'(sb.size()), '0);
            sb.delete();
        end
        @(negedge clk);
    endtask

    initial begin
        vec_t tbl[7];
        logic [W-1:0] ca[6], cb[6];
        int g0, s0, n;
        for (int i = 0; i < 6; i++) begin
            ca[i] = W'({$urandom(), $urandom(), $urandom(), $urandom()}) | W'(1);
            cb[i] = W'({$urandom(), $urandom(), $urandom(), $urandom()});
        end
        tbl[0] = '{2, W'(1), W'('h20), W'('h20)};
        tbl[1] = '{0, {1'b1, 106'b0}, W'(2), W'('h291)};
        tbl[2] = '{1, ca[0], cb[0], gf_mul(ca[0], cb[0])};
        tbl[3] = '{3, '0, cb[1], '0};
        tbl[4] = '{0, '1, W'(1), '1};
        tbl[5] = '{2, {1'b1, 106'b0}, {1'b1, 106'b0}, gf_mul({1'b1, 106'b0}, {1'b1, 106'b0})};
        tbl[6] = '{1, W'('h100), {7'b0000001, 100'b0}, W'('h522)};

        repeat (3) @(negedge clk);
        #1;
        chk("rst_req_ready", W'(req_ready), '0);
        chk("rst_resp_valid", W'(resp_valid), '0);
        chk("rst_resp_data", resp_data, '0);
        chk("rst_resp_err", W'(resp_err), '0);
        chk("rst_mul_start", W'(mul_start), '0);
        chk("rst_mul_op_a", mul_op_a, '0);
        chk("rst_mul_op_b", mul_op_b, '0);
        chk("rst_err_sticky", W'(err_sticky), '0);
        @(negedge clk);
        rst = 1'b0;

        g0 = glog.size();
        fork
            begin
                serve(0, ca[0], cb[0], gf_mul(ca[0], cb[0]), 1'b0, 1'b1);
                serve(0, ca[4], cb[4], gf_mul(ca[4], cb[4]), 1'b0, 1'b1);
            end
            begin
                serve(1, ca[1], cb[1], gf_mul(ca[1], cb[1]), 1'b0, 1'b1);
                serve(1, ca[5], cb[5], gf_mul(ca[5], cb[5]), 1'b0, 1'b1);
            end
            serve(2, ca[2], cb[2], gf_mul(ca[2], cb[2]), 1'b0, 1'b1);
            serve(3, ca[3], cb[3], gf_mul(ca[3], cb[3]), 1'b0, 1'b1);
        join
        drain();
        for (int i = 0; i < 6; i++) chk("grant_order", W'(glog[g0 + i]), W'(i % 4));

        for (int i = 0; i < 7; i++) begin
            s0 = nstart;
            serve(tbl[i].id, tbl[i].a, tbl[i].b, tbl[i].d, 1'b0, 1'b1);
            drain();
            chk("start_count", W'(nstart - s0), W'(1));
        end

        resp_ready = '0;
        serve(1, ca[2], cb[2], gf_mul(ca[2], cb[2]), 1'b0, 1'b1);
        n = 0;
        while (resp_valid == '0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("hold_reached", W'(resp_valid), W'(4'b0010));
        req_op_a[0 +: W] = ca[3];
        req_op_b[0 +: W] = cb[3];
        req_valid[0] = 1'b1;
        s0 = nstart;
        for (int i = 0; i < 10; i++) begin
            resp_ready = (i < 5) ? 4'b0000 : 4'b1101;
            #1;
            chk("hold_valid", W'(resp_valid), W'(4'b0010));
            chk("hold_data", resp_data, gf_mul(ca[2], cb[2]));
            chk("hold_req_ready", W'(req_ready), '0);
            @(negedge clk);
        end
        chk("hold_no_start", W'(nstart - s0), '0);
        resp_ready = '1;
        @(negedge clk);
        #1;
        chk("release_resp_valid", W'(resp_valid), '0);
        chk("release_req_ready", W'(req_ready), W'(4'b0001));
        mon_e.id = 0;
        mon_e.d = gf_mul(ca[3], cb[3]);
        mon_e.e = 1'b0;
        sb.push_back(mon_e);
        @(negedge clk);
        req_valid[0] = 1'b0;
        drain();

        mdl_hang = 1'b1;
        serve(3, ca[4], cb[4], '0, 1'b1, 1'b1);
        #1;
        chk("hang_start", W'(mul_start), W'(1));
        n = 0;
        while (resp_valid == '0 && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("timeout_cycles", W'(n), W'(TO + 1));
        mdl_hang = 1'b0;
        drain();
        chk("err_sticky_set", W'(err_sticky), W'(1));
        serve(0, ca[5], cb[5], gf_mul(ca[5], cb[5]), 1'b0, 1'b1);
        drain();

        serve(0, ca[0], cb[0], '0, 1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("wrst_req_ready", W'(req_ready), '0);
        chk("wrst_resp_valid", W'(resp_valid), '0);
        chk("wrst_resp_data", resp_data, '0);
        chk("wrst_resp_err", W'(resp_err), '0);
        chk("wrst_mul_start", W'(mul_start), '0);
        chk("wrst_mul_op_a", mul_op_a, '0);
        chk("wrst_mul_op_b", mul_op_b, '0);
        chk("wrst_err_sticky", W'(err_sticky), '0);
        repeat (12) @(negedge clk);
        #1;
        chk("late_done_no_resp", W'(resp_valid), '0);
        chk("late_done_sticky", W'(err_sticky), W'(1));
        @(negedge clk);
        g0 = glog.size();
        fork
            serve(1, ca[1], cb[2], gf_mul(ca[1], cb[2]), 1'b0, 1'b1);
            serve(3, ca[3], cb[4], gf_mul(ca[3], cb[4]), 1'b0, 1'b1);
        join
        drain();
        chk("post_rst_grant0", W'(glog[g0]), W'(1));
        chk("post_rst_grant1", W'(glog[g0 + 1]), W'(3));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        errors++;
        $display("FAIL global_timeout: bench did not complete");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/gf2m_mul_arbiter.md
# gf2m_mul_arbiter

Round-robin arbiter and sequencer that shares one digit-serial GF(2^m) multiplier among NREQ requesters. It captures operands through a valid/ready handshake and issues a single start pulse to the multiplier. It waits for the multiplier's done, with a watchdog, and returns the product to the granted requester through a per-requester response handshake. It sits between the ROLLO arithmetic clients (syndrome, key-gen, decode loops) and the shared multiplier instance.

## Interface
Parameters:
- WIDTH, 107, field degree m; operand and result width
- NREQ, 4, number of requesters (2..8)
- TIMEOUT, 16, maximum cycles in WAIT before abort; must exceed multiplier latency (WIDTH/16+2)

Ports:
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  NREQ  per-requester request valid
- req_ready  out  NREQ  per-requester accept; one-hot or zero
- req_op_a  in  NREQ*WIDTH  requester i uses bits [i*WIDTH +: WIDTH]
- req_op_b  in  NREQ*WIDTH  same packing as req_op_a
- resp_valid  out  NREQ  one-hot response valid to the owning requester
- resp_ready  in  NREQ  per-requester response accept
- resp_data  out  WIDTH  product a*b mod f(x), shared by all requesters
- resp_err  out  1  qualifies resp_data; 1 means watchdog abort, and resp_data is 0
- mul_start  out  1  one-cycle start pulse to the multiplier
- mul_op_a, mul_op_b  out  WIDTH  operands; held stable from ISSUE until the FSM leaves WAIT
- mul_done  in  1  multiplier done pulse
- mul_op_c  in  WIDTH  multiplier result, sampled in the cycle mul_done=1
- err_sticky  out  1  set by a watchdog abort or by mul_done outside WAIT; cleared only by rst

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - grant = first requester with req_valid=1, searching from ptr upward and wrapping modulo NREQ.
  - req_ready[grant]=1 combinationally; all other req_ready=0.
  - On handshake: capture op_a, op_b, and id=grant; set ptr <= (grant+1) mod NREQ; go to ISSUE.
  - If no request, stay in IDLE; ptr is unchanged.
- ISSUE:
  - mul_start=1 for exactly this cycle; clear the watchdog counter; go to WAIT.
- WAIT:
  - Watchdog counter increments each cycle.
  - mul_done=1: capture result <= mul_op_c and err <= 0; go to RESP.
  - Counter reaches TIMEOUT-1 without done: result <= 0, err <= 1, err_sticky <= 1; go to RESP.
  - mul_done and timeout in the same cycle: mul_done wins.
- RESP:
  - resp_valid[id]=1; resp_data=result; resp_err=err.
  - On resp_ready[id]: go to IDLE.
  - resp_ready on any other bit is ignored.
- A new grant requires being in IDLE, so at most one operation is in flight.
- mul_done seen in IDLE, ISSUE or RESP is ignored for data and sets err_sticky.
- req_ready is 0 in every state except IDLE; requests held valid are served later with no loss.
- Multiplier result is GF(2^WIDTH) with f(x)=x^107+x^9+x^7+x^4+1 at default parameters.
- The arbiter performs no arithmetic.

## Timing
- Reset values:
  - state=IDLE, ptr=0.
  - req_ready and resp_valid follow state: all 0 until the first request.
  - resp_data=0, resp_err=0, mul_start=0, mul_op_a=0, mul_op_b=0, err_sticky=0.
- Request handshake at cycle T0.
- mul_start=1 at T0+1.
- mul_done at Td; resp_valid at Td+1.
- Response handshake at Tr; IDLE at Tr+1; earliest next grant at Tr+1.
- Back-to-back throughput: one product per (multiplier latency + 3 + response wait) cycles.
- resp_data and resp_err are stable for the whole time resp_valid is high.
- rst asserted in any state: the next edge forces all reset values.
  - An in-flight result is discarded.
  - The multiplier shares the same reset, inverted at the top level.

## Test plan
- Single request, requester 2: a=0x1, b=0x20. Required: exactly one mul_start pulse; resp_valid=4'b0100; resp_data=0x20; resp_err=0.
- Reduction case, requester 0: a=1<<106, b=0x2. Required: resp_data=0x291.
- All four requesters hold req_valid continuously with distinct operands. Required: grant order 0,1,2,3,0,1; each result matches the golden model.
- resp_ready held low for 10 cycles during RESP. Required: resp_valid and resp_data stable; req_ready=0; no mul_start. Release resp_ready: IDLE on the next cycle.
- Multiplier model never asserts done. Required: after TIMEOUT cycles in WAIT, resp_valid with resp_err=1 and resp_data=0; err_sticky=1. The next request still completes normally.
- rst pulsed while in WAIT. Required: all outputs 0 on the next cycle; a late mul_done is ignored. A later simultaneous request from 1 and 3 grants 1 first (ptr=0).
